// File: rtl/uart_imem_loader.sv
// Boot loader: receives a word-count-prefixed program over UART (8N1) and writes it into
// instruction memory, holding the core in reset until the last word lands.
module uart_imem_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rx,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              load_done,
  output logic              load_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

  // state      | meaning
  // RX_IDLE    | line idle, waiting for a falling edge
  // RX_START   | counting to mid start bit to reject glitches
  // RX_DATA    | sampling 8 data bits, LSB first
  // RX_STOP    | sampling stop bit
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // state      | meaning
  // LEN_LO     | waiting for word count low byte
  // LEN_HI     | waiting for word count high byte
  // DATA       | assembling and writing words
  // DONE       | all words written, core released
  // ERR        | framing error or bad count, stuck until reset
  typedef enum logic [2:0] {LEN_LO, LEN_HI, DATA, DONE, ERR} ld_state_t;

  logic rx_s1_q, rx_s2_q, rx_prev_q;

  rx_state_t        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_valid, frame_err;

  ld_state_t        state_q, state_d;
  logic [15:0]      count_q, count_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [ADDR_W-1:0] word_idx_q, word_idx_d;
  logic [31:0]      word_buf_q, word_buf_d;
  logic             imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]      imem_wdata_q, imem_wdata_d;
  logic             core_rst_q, core_rst_d;
  logic [15:0]      new_count;
  logic [31:0]      word_next;

  // Preset to idle-high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= uart_rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_state_d = RX_START;
          clk_cnt_d  = HALF_M1;
        end
      end
      RX_START: begin
        if (clk_cnt_q != '0) begin
          clk_cnt_d = clk_cnt_q - CNT_W'(1);
        end else if (rx_s2_q) begin
          rx_state_d = RX_IDLE;
        end else begin
          rx_state_d = RX_DATA;
          clk_cnt_d  = FULL_M1;
          bit_cnt_d  = 3'd0;
        end
      end
      RX_DATA: begin
        if (clk_cnt_q != '0) begin
          clk_cnt_d = clk_cnt_q - CNT_W'(1);
        end else begin
          shift_d   = {rx_s2_q, shift_q[7:1]};
          clk_cnt_d = FULL_M1;
          if (bit_cnt_q == 3'd7) rx_state_d = RX_STOP;
          else bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      RX_STOP: begin
        if (clk_cnt_q != '0) begin
          clk_cnt_d = clk_cnt_q - CNT_W'(1);
        end else begin
          rx_state_d = RX_IDLE;
          byte_valid = rx_s2_q;
          frame_err  = !rx_s2_q;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state_q <= RX_IDLE;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    byte_idx_d   = byte_idx_q;
    word_idx_d   = word_idx_q;
    word_buf_d   = word_buf_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    core_rst_d   = core_rst_q;
    new_count    = {shift_q, count_q[7:0]};
    word_next    = word_buf_q;
    word_next[{byte_idx_q, 3'b000} +: 8] = shift_q;
    case (state_q)
      LEN_LO: begin
        if (frame_err) begin
          state_d = ERR;
        end else if (byte_valid) begin
          count_d[7:0] = shift_q;
          state_d      = LEN_HI;
        end
      end
      LEN_HI: begin
        if (frame_err) begin
          state_d = ERR;
        end else if (byte_valid) begin
          count_d = new_count;
          if (new_count == 16'd0 || {1'b0, new_count} > MAX_WORDS) begin
            state_d = ERR;
          end else begin
            state_d    = DATA;
            byte_idx_d = 2'd0;
            word_idx_d = '0;
          end
        end
      end
      DATA: begin
        if (frame_err) begin
          state_d = ERR;
        end else if (byte_valid) begin
          word_buf_d = word_next;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = word_idx_q;
            imem_wdata_d = word_next;
            // Last word holds the index so a full memory never wraps to 0.
            if (17'(word_idx_q) == {1'b0, count_q} - 17'd1) state_d = DONE;
            else word_idx_d = word_idx_q + ADDR_W'(1);
          end
        end
      end
      DONE: core_rst_d = 1'b1;
      ERR: ;
      default: state_d = ERR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= LEN_LO;
      count_q      <= '0;
      byte_idx_q   <= '0;
      word_idx_q   <= '0;
      word_buf_q   <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      core_rst_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      byte_idx_q   <= byte_idx_d;
      word_idx_q   <= word_idx_d;
      word_buf_q   <= word_buf_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      core_rst_q   <= core_rst_d;
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign core_rst   = core_rst_q;
  assign load_done  = (state_q == DONE);
  assign load_err   = (state_q == ERR);

endmodule

// File: tb/tb_uart_imem_loader.sv
// Scoreboard bench for uart_imem_loader: two instances (ADDR_W=8 and ADDR_W=2) at 4 clocks/bit.
module tb_uart_imem_loader;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx_a = 1'b1;
  logic rx_b = 1'b1;

  logic        a_we, a_core, a_done, a_err;
  logic [7:0]  a_addr;
  logic [31:0] a_wdata;
  logic        b_we, b_core, b_done, b_err;
  logic [1:0]  b_addr;
  logic [31:0] b_wdata;

  int total = 0;
  int bad   = 0;
  logic [39:0] exp_a[$];
  logic [33:0] exp_b[$];
  logic [7:0]  tx_q[$];

  uart_imem_loader #(.CLKS_PER_BIT(4), .ADDR_W(8)) dut_a (
    .clk(clk), .rst(rst), .uart_rx(rx_a), .imem_we(a_we), .imem_addr(a_addr),
    .imem_wdata(a_wdata), .core_rst(a_core), .load_done(a_done), .load_err(a_err)
  );

  uart_imem_loader #(.CLKS_PER_BIT(4), .ADDR_W(2)) dut_b (
    .clk(clk), .rst(rst), .uart_rx(rx_b), .imem_we(b_we), .imem_addr(b_addr),
    .imem_wdata(b_wdata), .core_rst(b_core), .load_done(b_done), .load_err(b_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, want end before 50000 cycles");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (a_we === 1'b1) begin
      logic [39:0] e;
      if (exp_a.size() == 0) begin
        total++;
        bad++;
        $display("FAIL a_unexpected_write: got addr %h data %h want no write", a_addr, a_wdata);
      end else begin
        e = exp_a.pop_front();
        chk("a_addr", 32'(a_addr), 32'(e[39:32]));
        chk("a_data", a_wdata, e[31:0]);
      end
    end
  end

  always @(negedge clk) begin
    if (b_we === 1'b1) begin
      logic [33:0] e;
      if (exp_b.size() == 0) begin
        total++;
        bad++;
        $display("FAIL b_unexpected_write: got addr %h data %h want no write", b_addr, b_wdata);
      end else begin
        e = exp_b.pop_front();
        chk("b_addr", 32'(b_addr), 32'(e[33:32]));
        chk("b_data", b_wdata, e[31:0]);
      end
    end
  end

  task automatic set_line(input int which, input logic v);
    #1;
    if (which == 0) rx_a = v;
    else rx_b = v;
  endtask

  task automatic send_byte(input int which, input logic [7:0] b, input logic stop);
    set_line(which, 1'b0);
    repeat (4) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      set_line(which, b[i]);
      repeat (4) @(posedge clk);
    end
    set_line(which, stop);
    repeat (4) @(posedge clk);
    set_line(which, 1'b1);
  endtask

  task automatic send_q(input int which);
    for (int i = 0; i < tx_q.size(); i++) send_byte(which, tx_q[i], 1'b1);
    tx_q = {};
  endtask

  task automatic add_word(input logic [31:0] w);
    tx_q.push_back(w[7:0]);
    tx_q.push_back(w[15:8]);
    tx_q.push_back(w[23:16]);
    tx_q.push_back(w[31:24]);
  endtask

  task automatic wait_we(input int which, input int addr, input string name);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(negedge clk);
      if (which == 0) hit = (a_we === 1'b1) && (int'(a_addr) == addr);
      else hit = (b_we === 1'b1) && (int'(b_addr) == addr);
    end
    if (!hit) begin
      total++;
      bad++;
      $display("FAIL %s: got no write to addr %0d want write within 300 cycles", name, addr);
    end
  endtask

  task automatic do_reset();
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
  endtask

  initial begin
    // reset values
    #15;
    chk("rst_we", 32'(a_we), 32'd0);
    chk("rst_addr", 32'(a_addr), 32'd0);
    chk("rst_wdata", a_wdata, 32'd0);
    chk("rst_core", 32'(a_core), 32'd0);
    chk("rst_done", 32'(a_done), 32'd0);
    chk("rst_err", 32'(a_err), 32'd0);
    #1 rst = 1'b1;
    @(posedge clk);

    // basic two-word program with release latency
    exp_a.push_back({8'd0, 32'h00500513});
    exp_a.push_back({8'd1, 32'h00A00593});
    tx_q = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'hA0, 8'h00};
    send_q(0);
    wait_we(0, 1, "t1_last_write");
    chk("t1_core_at_we", 32'(a_core), 32'd0);
    @(negedge clk);
    chk("t1_core_after", 32'(a_core), 32'd1);
    chk("t1_done", 32'(a_done), 32'd1);
    chk("t1_err", 32'(a_err), 32'd0);

    // zero count is an error; later frame ignored
    do_reset();
    tx_q = '{8'h00, 8'h00};
    send_q(0);
    repeat (4) @(negedge clk);
    chk("t2_err", 32'(a_err), 32'd1);
    chk("t2_core", 32'(a_core), 32'd0);
    tx_q = '{8'h01, 8'h00};
    add_word(32'h12345678);
    send_q(0);
    repeat (10) @(negedge clk);
    chk("t2_err_sticky", 32'(a_err), 32'd1);
    chk("t2_done", 32'(a_done), 32'd0);
    chk("t2_core_held", 32'(a_core), 32'd0);

    // ADDR_W=2: count too large, then exactly full
    do_reset();
    tx_q = '{8'h05, 8'h00};
    send_q(1);
    repeat (4) @(negedge clk);
    chk("t3_over_err", 32'(b_err), 32'd1);
    do_reset();
    tx_q = '{8'h04, 8'h00};
    for (int k = 0; k < 4; k++) begin
      logic [31:0] w;
      w = 32'hC0DE0000 | (32'(k) * 32'h00010101) + 32'h11;
      add_word(w);
      exp_b.push_back({2'(k), w});
    end
    send_q(1);
    wait_we(1, 3, "t3_last_write");
    @(negedge clk);
    chk("t3_core", 32'(b_core), 32'd1);
    chk("t3_done", 32'(b_done), 32'd1);
    chk("t3_err", 32'(b_err), 32'd0);
    repeat (50) @(negedge clk);

    // framing error on third data byte
    do_reset();
    send_byte(0, 8'h04, 1'b1);
    send_byte(0, 8'h00, 1'b1);
    send_byte(0, 8'hAA, 1'b1);
    send_byte(0, 8'hBB, 1'b1);
    send_byte(0, 8'hCC, 1'b0);
    for (int i = 0; i < 5; i++) send_byte(0, 8'(8'h40 + i), 1'b1);
    repeat (10) @(negedge clk);
    chk("t4_err", 32'(a_err), 32'd1);
    chk("t4_core", 32'(a_core), 32'd0);
    chk("t4_done", 32'(a_done), 32'd0);

    // one-cycle glitch, then a good frame
    do_reset();
    @(posedge clk);
    #1 rx_a = 1'b0;
    @(posedge clk);
    #1 rx_a = 1'b1;
    repeat (20) @(negedge clk);
    chk("t5_glitch_err", 32'(a_err), 32'd0);
    chk("t5_glitch_done", 32'(a_done), 32'd0);
    exp_a.push_back({8'd0, 32'hDEADBEEF});
    tx_q = '{8'h01, 8'h00};
    add_word(32'hDEADBEEF);
    send_q(0);
    wait_we(0, 0, "t5_write");
    @(negedge clk);
    chk("t5_core", 32'(a_core), 32'd1);
    chk("t5_err", 32'(a_err), 32'd0);

    // reset after two of four words, then a full reload
    do_reset();
    exp_a.push_back({8'd0, 32'h01020304});
    exp_a.push_back({8'd1, 32'hA5A55A5A});
    tx_q = '{8'h04, 8'h00};
    add_word(32'h01020304);
    add_word(32'hA5A55A5A);
    send_q(0);
    wait_we(0, 1, "t6_second_write");
    send_byte(0, 8'h77, 1'b1);
    send_byte(0, 8'h66, 1'b1);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("t6_abort_we", 32'(a_we), 32'd0);
    chk("t6_abort_addr", 32'(a_addr), 32'd0);
    chk("t6_abort_wdata", a_wdata, 32'd0);
    chk("t6_abort_core", 32'(a_core), 32'd0);
    chk("t6_abort_done", 32'(a_done), 32'd0);
    chk("t6_abort_err", 32'(a_err), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    tx_q = '{8'h04, 8'h00};
    for (int k = 0; k < 4; k++) begin
      logic [31:0] w;
      w = 32'h80000000 + 32'(k) * 32'h01010101;
      add_word(w);
      exp_a.push_back({8'(k), w});
    end
    send_q(0);
    wait_we(0, 3, "t6_last_write");
    chk("t6_core_at_we", 32'(a_core), 32'd0);
    @(negedge clk);
    chk("t6_core", 32'(a_core), 32'd1);
    chk("t6_done", 32'(a_done), 32'd1);

    repeat (10) @(negedge clk);
    chk("a_queue_empty", 32'(exp_a.size()), 32'd0);
    chk("b_queue_empty", 32'(exp_b.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
